pw_operand_feeder: RTL and testbench

Sequencer that drives the pointwise (1x1) MAC array. It owns one feature-map read port and one weight read port, and loads up to 12 input-channel pixels and 12 weights into lane registers. It then pulses conv_PW_en for exactly one cycle, captures the MAC result on the following cycle and forwards it with a write address. It sits between the on-chip feature-map and weight buffers and the conv_PW MAC, on the driving side of the MAC's p/w/en interface.

---
 rtl/pw_feeder_pkg.sv | 31 +++
 rtl/pw_lane_loader.sv | 58 +++++
 rtl/pw_operand_feeder.sv | 143 ++++++++++++++
 tb/tb_pw_operand_feeder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pw_feeder_pkg.sv
// ----------------------------------------------------------------------------
// pw_feeder_pkg : shared widths, state encoding and channel clamp for the feeder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pw_feeder_pkg;
   localparam int SIZE   = 8;
   localparam int MAX_CH = 12;
   localparam int FA_W   = 17;
   localparam int OA_W   = 20;
   localparam int WA_W   = 11;
   localparam int M2_W   = 13;

   localparam logic [3:0] C_FILT_MAX = 4'd11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LDP   = 3'd1,
      S_LDW   = 3'd2,
      S_ISSUE = 3'd3,
      S_CAP   = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   function automatic logic [3:0] clamp_filt(input logic [6:0] f);
      return (f > 7'(C_FILT_MAX)) ? C_FILT_MAX : f[3:0];
   endfunction
endpackage

`default_nettype wire

// File: rtl/pw_lane_loader.sv
// ----------------------------------------------------------------------------
// pw_lane_loader : strided burst reader that fills MAX_CH lane registers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pw_lane_loader
   import pw_feeder_pkg::*;
#(
   parameter int AW = FA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_go,
   input  logic [AW-1:0]            i_base,
   input  logic [AW-1:0]            i_stride,
   input  logic [3:0]               i_count,
   input  logic [SIZE-1:0]          i_rd_data,
   output logic                     o_rd_en,
   output logic [AW-1:0]            o_addr,
   output logic [MAX_CH*SIZE-1:0]   o_lanes,
   output logic                     o_last
);

   logic [3:0]             r_k;
   logic [MAX_CH*SIZE-1:0] r_lanes;

   assign o_rd_en = i_go && (r_k <= i_count);
   assign o_last  = i_go && (r_k == i_count + 4'd1);
   assign o_addr  = o_rd_en ? (AW'(r_k) * i_stride + i_base) : '0;
   assign o_lanes = r_lanes;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_k <= '0;
      else if (o_last)
         r_k <= '0;
      else if (i_go)
         r_k <= r_k + 4'd1;
   end

   // Read data trails the strobe by one cycle, so cycle k captures lane k-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lanes <= '0;
      end else if (i_go) begin
         for (int j = 0; j < MAX_CH; j++) begin
            if (4'(j) > i_count)
               r_lanes[j*SIZE +: SIZE] <= '0;
            else if ((r_k != 4'd0) && (4'(j) == r_k - 4'd1))
               r_lanes[j*SIZE +: SIZE] <= i_rd_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/pw_operand_feeder.sv
// ----------------------------------------------------------------------------
// pw_operand_feeder : sequences pixel/weight lane loads and result capture for the 1x1 MAC
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pw_operand_feeder
   import pw_feeder_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [6:0]             matrix,
   input  logic [12:0]            matrix2,
   input  logic [6:0]             filt,
   input  logic [6:0]             n_out,
   output logic                   fm_rd_en,
   output logic [FA_W-1:0]        fm_addr,
   input  logic [SIZE-1:0]        fm_rd_data,
   output logic                   wt_rd_en,
   output logic [10:0]            wt_addr,
   input  logic [SIZE-1:0]        wt_rd_data,
   output logic [12*SIZE-1:0]     p_bus,
   output logic [12*SIZE-1:0]     w_bus,
   output logic [14:0]            i,
   output logic                   conv_PW_en,
   input  logic [2*SIZE-2:0]      y_in,
   output logic                   y_valid,
   output logic [2*SIZE-2:0]      y_out,
   output logic [OA_W-1:0]        y_addr,
   output logic                   busy,
   output logic                   done
);

   state_t          r_state;
   state_t          w_next;
   logic [3:0]      r_filt;
   logic [6:0]      r_nout;
   logic [M2_W-1:0] r_m2;
   logic [14:0]     r_i;
   logic [6:0]      r_o;
   logic            w_fm_last;
   logic            w_wt_last;
   logic            w_more_o;
   logic            w_more_px;
   logic            w_unused_matrix;

   // The line length only matters to the MAC; it is not needed here.
   assign w_unused_matrix = ^matrix;

   assign w_more_o  = (r_o < r_nout);
   assign w_more_px = (r_i < ({2'b00, r_m2} - 15'd1));
   assign i         = r_i;

   pw_lane_loader #(.AW(FA_W)) u_fm_loader (
      .clk       (clk),
      .rst       (rst),
      .i_go      (r_state == S_LDP),
      .i_base    (FA_W'(r_i)),
      .i_stride  (FA_W'(r_m2)),
      .i_count   (r_filt),
      .i_rd_data (fm_rd_data),
      .o_rd_en   (fm_rd_en),
      .o_addr    (fm_addr),
      .o_lanes   (p_bus),
      .o_last    (w_fm_last)
   );

   pw_lane_loader #(.AW(WA_W)) u_wt_loader (
      .clk       (clk),
      .rst       (rst),
      .i_go      (r_state == S_LDW),
      .i_base    (WA_W'(r_o) * WA_W'(MAX_CH)),
      .i_stride  (WA_W'(1)),
      .i_count   (r_filt),
      .i_rd_data (wt_rd_data),
      .o_rd_en   (wt_rd_en),
      .o_addr    (wt_addr),
      .o_lanes   (w_bus),
      .o_last    (w_wt_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = (matrix2 == '0) ? S_FIN : S_LDP;
         S_LDP:   if (w_fm_last) w_next = S_LDW;
         S_LDW:   if (w_wt_last) w_next = S_ISSUE;
         S_ISSUE: w_next = S_CAP;
         S_CAP:   w_next = w_more_o ? S_LDW : (w_more_px ? S_LDP : S_FIN);
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (r_state != S_IDLE);
      done       = (r_state == S_FIN);
      conv_PW_en = (r_state == S_ISSUE);
      y_valid    = 1'b0;
      y_out      = '0;
      y_addr     = '0;
      if (r_state == S_CAP) begin
         y_valid = 1'b1;
         y_out   = y_in;
         y_addr  = OA_W'(r_o) * OA_W'(r_m2) + OA_W'(r_i);
      end
   end

   // Pixel lanes stay loaded while every output filter is swept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_filt <= '0;
         r_nout <= '0;
         r_m2   <= '0;
         r_i    <= '0;
         r_o    <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_filt <= clamp_filt(filt);
         r_nout <= n_out;
         r_m2   <= matrix2;
         r_i    <= '0;
         r_o    <= '0;
      end else if (r_state == S_CAP) begin
         if (w_more_o) begin
            r_o <= r_o + 7'd1;
         end else if (w_more_px) begin
            r_o <= '0;
            r_i <= r_i + 15'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pw_operand_feeder.sv
// ----------------------------------------------------------------------------
// tb_pw_operand_feeder : directed bench with buffer/MAC models and event logs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pw_operand_feeder;
   import pw_feeder_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [6:0]  matrix = '0;
   logic [12:0] matrix2 = '0;
   logic [6:0]  filt = '0;
   logic [6:0]  n_out = '0;
   logic        fm_rd_en, wt_rd_en, conv_PW_en, y_valid, busy, done;
   logic [16:0] fm_addr;
   logic [10:0] wt_addr;
   logic [7:0]  fm_rd_data = '0;
   logic [7:0]  wt_rd_data = '0;
   logic [95:0] p_bus, w_bus;
   logic [14:0] i;
   logic [14:0] y_in = '0;
   logic [14:0] y_out;
   logic [19:0] y_addr;

   logic signed [7:0] fm_mem [0:255];
   logic signed [7:0] wt_mem [0:255];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int t0 = 0;
   int fm_q[$], wt_q[$], ya_q[$], yc_q[$], cv_q[$], dn_q[$];
   logic [14:0] yv_q[$];
   logic [95:0] pb_q[$];
   int b_fm, b_wt, b_y, b_cv, b_dn;

   pw_operand_feeder dut (
      .clk(clk), .rst(rst), .start(start), .matrix(matrix), .matrix2(matrix2),
      .filt(filt), .n_out(n_out), .fm_rd_en(fm_rd_en), .fm_addr(fm_addr),
      .fm_rd_data(fm_rd_data), .wt_rd_en(wt_rd_en), .wt_addr(wt_addr),
      .wt_rd_data(wt_rd_data), .p_bus(p_bus), .w_bus(w_bus), .i(i),
      .conv_PW_en(conv_PW_en), .y_in(y_in), .y_valid(y_valid), .y_out(y_out),
      .y_addr(y_addr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [14:0] mac(input logic [95:0] p, input logic [95:0] w);
      int s = 0;
      logic signed [7:0] a, b;
      for (int k = 0; k < 12; k++) begin
         a = p[k*8 +: 8];
         b = w[k*8 +: 8];
         s += int'(a) * int'(b);
      end
      return 15'(s);
   endfunction

   // Buffers answer one cycle after the strobe; the MAC registers on the enable edge.
   always @(posedge clk) begin
      if (fm_rd_en)   fm_rd_data <= fm_mem[fm_addr[7:0]];
      if (wt_rd_en)   wt_rd_data <= wt_mem[wt_addr[7:0]];
      if (conv_PW_en) y_in <= mac(p_bus, w_bus);
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (fm_rd_en)   fm_q.push_back(int'(fm_addr));
         if (wt_rd_en)   wt_q.push_back(int'(wt_addr));
         if (conv_PW_en) begin cv_q.push_back(cyc); pb_q.push_back(p_bus); end
         if (y_valid) begin
            ya_q.push_back(int'(y_addr));
            yv_q.push_back(y_out);
            yc_q.push_back(cyc);
         end
         if (done) dn_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mark();
      b_fm = fm_q.size(); b_wt = wt_q.size(); b_y = ya_q.size();
      b_cv = cv_q.size(); b_dn = dn_q.size();
   endtask

   task automatic clr_mem();
      for (int a = 0; a < 256; a++) begin fm_mem[a] = '0; wt_mem[a] = '0; end
   endtask

   task automatic start_layer(input logic [6:0] f, input logic [6:0] no, input logic [12:0] m2);
      @(posedge clk); #1;
      filt = f; n_out = no; matrix2 = m2; matrix = 7'd2;
      start = 1'b1; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (dn_q.size() == b_dn && n < budget) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
   endtask

   task automatic load_t2_mem();
      clr_mem();
      for (int k = 0; k < 3; k++) begin
         for (int px = 0; px < 4; px++) fm_mem[k*4+px] = 8'(k + 1);
         wt_mem[k] = 8'sd1;
         wt_mem[12+k] = 8'sd2;
      end
   endtask

   initial begin
      int idx, mx, hit;
      clr_mem();
      #12;
      check("reset_ctrl", {busy, done, fm_rd_en, wt_rd_en, conv_PW_en, y_valid}, 96'd0);
      check("reset_data", {fm_addr, wt_addr, i, y_out, y_addr}, 96'd0);
      check("reset_lanes", p_bus | w_bus, 96'd0);
      @(posedge clk); #1; rst = 1'b0;

      // single channel, single filter, single pixel
      fm_mem[0] = 8'sd5; wt_mem[0] = -8'sd3;
      mark(); start_layer(7'd0, 7'd0, 13'd1); wait_done(50);
      check("t1_fm_reads", fm_q.size() - b_fm, 1);
      check("t1_conv_cyc", cv_q[b_cv] - t0, 5);
      check("t1_yv_cyc", yc_q[b_y] - t0, 6);
      check("t1_y_out", yv_q[b_y], 15'h7ff1);
      check("t1_y_addr", ya_q[b_y], 0);
      check("t1_done_cyc", dn_q[b_dn] - t0, 7);
      check("t1_busy_after", busy, 0);

      // 3 channels, 2 filters, 4 pixels
      load_t2_mem();
      mark(); start_layer(7'd2, 7'd1, 13'd4); wait_done(200);
      check("t2_fm_cnt", fm_q.size() - b_fm, 12);
      check("t2_wt_cnt", wt_q.size() - b_wt, 24);
      check("t2_y_cnt", ya_q.size() - b_y, 8);
      for (int px = 0; px < 4; px++) begin
         for (int k = 0; k < 3; k++)
            check($sformatf("t2_fm_addr_%0d_%0d", px, k), fm_q[b_fm + px*3 + k], k*4 + px);
         for (int o = 0; o < 2; o++) begin
            for (int k = 0; k < 3; k++)
               check($sformatf("t2_wt_addr_%0d_%0d_%0d", px, o, k),
                     wt_q[b_wt + px*6 + o*3 + k], o*12 + k);
            idx = b_y + px*2 + o;
            check($sformatf("t2_y_addr_%0d_%0d", px, o), ya_q[idx], o*4 + px);
            check($sformatf("t2_y_out_%0d_%0d", px, o), yv_q[idx], (o + 1) * 6);
         end
      end
      check("t2_p_bus", pb_q[b_cv], 96'h030201);
      check("t2_done_cyc", dn_q[b_dn] - t0, 65);

      // channel count above the lane count is clamped
      clr_mem();
      for (int a = 0; a < 36; a++) fm_mem[a] = 8'(a / 3 - 5);
      for (int k = 0; k < 12; k++) wt_mem[k] = 8'(k + 1);
      mark(); start_layer(7'd20, 7'd0, 13'd3); wait_done(300);
      mx = 0;
      for (int n = b_fm; n < fm_q.size(); n++) if (fm_q[n] > mx) mx = fm_q[n];
      check("t3_fm_cnt", fm_q.size() - b_fm, 36);
      check("t3_fm_max", mx, 35);
      check("t3_p12", pb_q[b_cv][95:88], 8'd6);
      check("t3_y_out", yv_q[b_y], 15'd182);
      check("t3_done_cyc", dn_q[b_dn] - t0, 85);

      // empty feature map
      mark(); start_layer(7'd2, 7'd1, 13'd0); wait_done(20);
      check("t4_done_cyc", dn_q[b_dn] - t0, 1);
      check("t4_rd_cnt", (fm_q.size() - b_fm) + (wt_q.size() - b_wt), 0);
      check("t4_conv_y_cnt", (cv_q.size() - b_cv) + (ya_q.size() - b_y), 0);

      // asynchronous abort during a weight load of pixel 2
      load_t2_mem();
      mark(); start_layer(7'd2, 7'd1, 13'd4);
      hit = 0;
      for (int n = 0; n < 400 && hit == 0; n++) begin
         @(negedge clk);
         if (wt_rd_en && i == 15'd2) hit = 1;
      end
      check("t5_reached_px2", hit, 1);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_ctrl", {busy, done, fm_rd_en, wt_rd_en, conv_PW_en, y_valid}, 96'd0);
      check("t5_rst_data", {fm_addr, wt_addr, i, y_out, y_addr}, 96'd0);
      check("t5_rst_lanes", p_bus | w_bus, 96'd0);
      mark();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      check("t5_no_late_out", (ya_q.size() - b_y) + (dn_q.size() - b_dn), 0);
      mark(); start_layer(7'd2, 7'd1, 13'd4); wait_done(200);
      check("t5_restart_fm0", fm_q[b_fm], 0);
      check("t5_restart_y0", ya_q[b_y], 0);
      check("t5_restart_ycnt", ya_q.size() - b_y, 8);

      // start hammered while busy, and once more on the done cycle
      mark();
      @(posedge clk); #1;
      filt = 7'd0; n_out = 7'd1; matrix2 = 13'd3; start = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk); #1;
         if (done) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            break;
         end
         start = ~start;
      end
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("t6_y_cnt", ya_q.size() - b_y, 6);
      check("t6_conv_cnt", cv_q.size() - b_cv, 6);
      check("t6_done_cnt", dn_q.size() - b_dn, 1);
      check("t6_busy_after", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
